// File: rtl/moxie_wb_upsizer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// moxie_wb_upsizer: 16-bit big-endian Wishbone to 32-bit classic bridge
// with a one-word read buffer and a bus-timeout watchdog.  Rev 1.0
// ----------------------------------------------------------------------------
module moxie_wb_upsizer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit BUF_EN         = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [31:0] s_adr_i,
  input  logic [15:0] s_dat_i,
  output logic [15:0] s_dat_o,
  input  logic [1:0]  s_sel_i,
  input  logic        s_we_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  output logic        s_ack_o,
  output logic        s_err_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  input  logic        m_err_i
);

  localparam int            C_CW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [C_CW-1:0] C_TMO  = C_CW'(TIMEOUT_CYCLES);
  localparam bit            C_TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_buf_valid;
  logic [29:0]     r_buf_tag;
  logic [31:0]     r_buf_data;
  logic            r_half;
  logic            r_abort;
  logic [C_CW-1:0] r_cnt;

  logic            w_req;
  logic            w_tag_match;
  logic            w_hit;
  logic [C_CW-1:0] w_cnt_nxt;
  logic            w_timeout;
  logic            w_live;
  logic [15:0]     w_rd_half;
  logic [15:0]     w_buf_half;
  logic            w_unused;

  assign w_req       = s_cyc_i & s_stb_i;
  assign w_tag_match = r_buf_valid && (r_buf_tag == s_adr_i[31:2]);
  assign w_hit       = BUF_EN && w_tag_match && !s_we_i && !flush_i;
  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_timeout   = C_TMO_EN && (w_cnt_nxt == C_TMO);
  // Core may abandon the cycle mid-flight; the fabric cycle still finishes.
  assign w_live      = s_cyc_i && !r_abort;
  assign w_rd_half   = r_half ? m_dat_i[15:0] : m_dat_i[31:16];
  assign w_buf_half  = s_adr_i[1] ? r_buf_data[15:0] : r_buf_data[31:16];
  assign w_unused    = s_adr_i[0];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_data  <= '0;
      r_half      <= 1'b0;
      r_abort     <= 1'b0;
      r_cnt       <= '0;
      s_dat_o     <= '0;
      s_ack_o     <= 1'b0;
      s_err_o     <= 1'b0;
      m_adr_o     <= '0;
      m_dat_o     <= '0;
      m_sel_o     <= '0;
      m_we_o      <= 1'b0;
      m_cyc_o     <= 1'b0;
      m_stb_o     <= 1'b0;
    end else begin
      s_ack_o <= 1'b0;
      s_err_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              s_dat_o <= w_buf_half;
              s_ack_o <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              m_adr_o <= {s_adr_i[31:2], 2'b00};
              m_dat_o <= {s_dat_i, s_dat_i};
              m_sel_o <= !s_we_i   ? 4'hF :
                         s_adr_i[1] ? {2'b00, s_sel_i} : {s_sel_i, 2'b00};
              m_we_o  <= s_we_i;
              m_cyc_o <= 1'b1;
              m_stb_o <= 1'b1;
              r_half  <= s_adr_i[1];
              r_cnt   <= '0;
              r_abort <= 1'b0;
              r_state <= ST_REQ;
              if (s_we_i && w_tag_match) r_buf_valid <= 1'b0;
            end
          end
        end
        ST_REQ: begin
          r_cnt <= w_cnt_nxt;
          if (!s_cyc_i) r_abort <= 1'b1;
          if (m_err_i || w_timeout) begin
            m_cyc_o     <= 1'b0;
            m_stb_o     <= 1'b0;
            s_err_o     <= w_live;
            r_buf_valid <= 1'b0;
            r_state     <= ST_DONE;
          end else if (m_ack_i) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            s_ack_o <= w_live;
            if (!m_we_o) begin
              r_buf_data  <= m_dat_i;
              r_buf_tag   <= m_adr_o[31:2];
              r_buf_valid <= BUF_EN;
              if (w_live) s_dat_o <= w_rd_half;
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      // Flush overrides any fill or invalidate made above on this edge.
      if (flush_i) r_buf_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_moxie_wb_upsizer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_moxie_wb_upsizer: directed bench for the 16-to-32 Wishbone upsizer.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_moxie_wb_upsizer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] s_adr = '0;
  logic [15:0] s_dat_w = '0;
  logic [15:0] s_dat_r;
  logic [1:0]  s_sel = '0;
  logic        s_we = 1'b0;
  logic        s_cyc = 1'b0;
  logic        s_stb = 1'b0;
  logic        s_ack;
  logic        s_err;
  logic [31:0] m_adr;
  logic [31:0] m_dat_w;
  logic [31:0] m_dat_r = '0;
  logic [3:0]  m_sel;
  logic        m_we;
  logic        m_cyc;
  logic        m_stb;
  logic        m_ack = 1'b0;
  logic        m_err = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  moxie_wb_upsizer #(
    .TIMEOUT_CYCLES(4),
    .BUF_EN        (1'b1)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(flush),
    .s_adr_i(s_adr),
    .s_dat_i(s_dat_w),
    .s_dat_o(s_dat_r),
    .s_sel_i(s_sel),
    .s_we_i (s_we),
    .s_cyc_i(s_cyc),
    .s_stb_i(s_stb),
    .s_ack_o(s_ack),
    .s_err_o(s_err),
    .m_adr_o(m_adr),
    .m_dat_o(m_dat_w),
    .m_dat_i(m_dat_r),
    .m_sel_o(m_sel),
    .m_we_o (m_we),
    .m_cyc_o(m_cyc),
    .m_stb_o(m_stb),
    .m_ack_i(m_ack),
    .m_err_i(m_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] adr, input logic we, input logic [15:0] dat,
                     input logic [1:0] sel);
    s_adr = adr; s_we = we; s_dat_w = dat; s_sel = sel;
    s_cyc = 1'b1; s_stb = 1'b1;
  endtask

  task automatic idle_master();
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
  endtask

  task automatic fab(input logic ack, input logic err, input logic [31:0] dat);
    m_ack = ack; m_err = err; m_dat_r = dat;
  endtask

  initial begin
    // Reset held for two edges.
    tick(); tick();
    chk("rst_s_dat", {16'h0, s_dat_r}, 32'h0);
    chk("rst_acks", {30'h0, s_ack, s_err}, 32'h0);
    chk("rst_m_adr", m_adr, 32'h0);
    chk("rst_m_dat", m_dat_w, 32'h0);
    chk("rst_m_ctl", {25'h0, m_sel, m_we, m_cyc, m_stb}, 32'h0);

    // Miss at 0x1000, fabric acks on the third REQ edge.
    rst = 1'b1;
    req(32'h1000, 1'b0, 16'h0, 2'b11);
    tick();
    chk("miss_cyc", {30'h0, m_cyc, m_stb}, 32'h3);
    chk("miss_adr", m_adr, 32'h1000);
    chk("miss_sel", {28'h0, m_sel}, 32'hF);
    chk("miss_we", {31'h0, m_we}, 32'h0);
    tick();
    chk("miss_wait1", {29'h0, m_cyc, s_ack, s_err}, 32'h4);
    tick();
    chk("miss_wait2", {29'h0, m_cyc, s_ack, s_err}, 32'h4);
    fab(1'b1, 1'b0, 32'hAABBCCDD);
    tick();
    fab(1'b0, 1'b0, 32'h0);
    idle_master();
    chk("miss_ack", {30'h0, s_ack, s_err}, 32'h2);
    chk("miss_dat", {16'h0, s_dat_r}, 32'hAABB);
    chk("miss_drop", {30'h0, m_cyc, m_stb}, 32'h0);
    tick();
    chk("miss_ack_pulse", {31'h0, s_ack}, 32'h0);

    // Buffer hit on the paired halfword.
    req(32'h1002, 1'b0, 16'h0, 2'b11);
    tick();
    idle_master();
    chk("hit_ack", {31'h0, s_ack}, 32'h1);
    chk("hit_dat", {16'h0, s_dat_r}, 32'hCCDD);
    chk("hit_nocyc", {31'h0, m_cyc}, 32'h0);
    tick();
    chk("hit_done", {30'h0, s_ack, m_cyc}, 32'h0);

    // Write to the buffered word, low half.
    req(32'h1002, 1'b1, 16'h1234, 2'b11);
    tick();
    chk("wr_sel", {28'h0, m_sel}, 32'h3);
    chk("wr_dat", m_dat_w, 32'h12341234);
    chk("wr_adr", m_adr, 32'h1000);
    chk("wr_ctl", {30'h0, m_we, m_cyc}, 32'h3);
    fab(1'b1, 1'b0, 32'h0);
    tick();
    fab(1'b0, 1'b0, 32'h0);
    idle_master();
    chk("wr_ack", {29'h0, s_ack, s_err, m_cyc}, 32'h4);
    chk("wr_keep_dat", {16'h0, s_dat_r}, 32'hCCDD);
    tick();

    // Upper-half write lane placement.
    req(32'h2000, 1'b1, 16'h00A5, 2'b10);
    tick();
    chk("wr_hi_sel", {28'h0, m_sel}, 32'h8);
    fab(1'b1, 1'b0, 32'h0);
    tick();
    fab(1'b0, 1'b0, 32'h0);
    idle_master();
    tick();

    // Re-read 0x1000: must go to the bus after the invalidating write.
    req(32'h1000, 1'b0, 16'h0, 2'b11);
    tick();
    chk("inv_miss", {30'h0, m_cyc, s_ack}, 32'h2);
    fab(1'b1, 1'b0, 32'h11223344);
    tick();
    fab(1'b0, 1'b0, 32'h0);
    idle_master();
    chk("inv_dat", {16'h0, s_dat_r}, 32'h1122);
    tick();

    // Error and ack together: error wins.
    req(32'h2000, 1'b0, 16'h0, 2'b11);
    tick();
    fab(1'b1, 1'b1, 32'h99999999);
    tick();
    fab(1'b0, 1'b0, 32'h0);
    idle_master();
    chk("err_resp", {29'h0, s_ack, s_err, m_cyc}, 32'h2);
    chk("err_keep_dat", {16'h0, s_dat_r}, 32'h1122);
    tick();
    chk("err_pulse", {31'h0, s_err}, 32'h0);

    // Watchdog: four cycles in REQ with no fabric response.
    req(32'h3000, 1'b0, 16'h0, 2'b11);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("tmo_wait", {30'h0, m_cyc, s_err}, 32'h2);
      tick();
    end
    chk("tmo_wait", {30'h0, m_cyc, s_err}, 32'h2);
    tick();
    idle_master();
    chk("tmo_err", {29'h0, m_cyc, s_err, s_ack}, 32'h2);
    tick();
    chk("tmo_pulse", {31'h0, s_err}, 32'h0);

    // Flush on the fill edge leaves the buffer invalid.
    req(32'h1000, 1'b0, 16'h0, 2'b11);
    tick();
    chk("fl_miss", {31'h0, m_cyc}, 32'h1);
    fab(1'b1, 1'b0, 32'h55667788);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fab(1'b0, 1'b0, 32'h0);
    idle_master();
    chk("fl_ack", {16'h0, s_dat_r}, 32'h5566);
    tick();
    req(32'h1002, 1'b0, 16'h0, 2'b11);
    tick();
    chk("fl_repeat_bus", {30'h0, m_cyc, s_ack}, 32'h2);
    fab(1'b1, 1'b0, 32'h55667788);
    tick();
    fab(1'b0, 1'b0, 32'h0);
    idle_master();
    chk("fl_repeat_dat", {16'h0, s_dat_r}, 32'h7788);
    tick();

    // Flush on a would-be hit forces a bus cycle.
    req(32'h1000, 1'b0, 16'h0, 2'b11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_hit_bus", {30'h0, m_cyc, s_ack}, 32'h2);
    fab(1'b1, 1'b0, 32'h55667788);
    tick();
    fab(1'b0, 1'b0, 32'h0);
    idle_master();
    tick();

    // Abort: core drops cyc in REQ; fabric completes, fill still happens.
    req(32'h4000, 1'b0, 16'h0, 2'b11);
    tick();
    idle_master();
    tick();
    chk("ab_hold", {31'h0, m_cyc}, 32'h1);
    fab(1'b1, 1'b0, 32'hDEADBEEF);
    tick();
    fab(1'b0, 1'b0, 32'h0);
    chk("ab_noack", {29'h0, m_cyc, s_ack, s_err}, 32'h0);
    tick();
    req(32'h4002, 1'b0, 16'h0, 2'b11);
    tick();
    idle_master();
    chk("ab_fill_hit", {15'h0, s_ack, s_dat_r}, 32'h1BEEF);
    chk("ab_fill_nocyc", {31'h0, m_cyc}, 32'h0);
    tick();

    // Reset in the middle of a fabric cycle.
    req(32'h5000, 1'b0, 16'h0, 2'b11);
    tick();
    chk("mr_cyc", {31'h0, m_cyc}, 32'h1);
    rst = 1'b0;
    tick();
    chk("mr_drop", {29'h0, m_cyc, m_stb, s_ack}, 32'h0);
    chk("mr_s_dat", {16'h0, s_dat_r}, 32'h0);
    rst = 1'b1;
    idle_master();
    tick();
    chk("mr_noack", {30'h0, s_ack, s_err}, 32'h0);
    req(32'h4002, 1'b0, 16'h0, 2'b11);
    tick();
    chk("mr_buf_inv", {30'h0, m_cyc, s_ack}, 32'h2);
    fab(1'b1, 1'b0, 32'hCAFEF00D);
    tick();
    fab(1'b0, 1'b0, 32'h0);
    idle_master();
    chk("mr_dat", {16'h0, s_dat_r}, 32'hF00D);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
